// File: rtl/dmem_pkg.sv
// Shared encodings and types for the data-side load/store responder.
package dmem_pkg;

    localparam logic [2:0] W_BYTE = 3'd0;
    localparam logic [2:0] W_HALF = 3'd1;
    localparam logic [2:0] W_WORD = 3'd2;

    // Widest tag any legal LINES can need (LINES >= 2); narrower tags are zero-extended.
    localparam int TAG_MAX_W = 29;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_MISS,
        S_WR
    } state_t;

    typedef struct packed {
        logic                 v;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          data;
    } line_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: load extract/extend from a cached word, store replicate/strobe.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  ld_off_i,
    input  logic [2:0]  rwidth_i,
    input  logic        rsign_i,
    input  logic [31:0] line_data_i,
    output logic [31:0] ld_data_o,
    input  logic [1:0]  st_off_i,
    input  logic [2:0]  wwidth_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] st_data_o,
    output logic [3:0]  st_strb_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        case (ld_off_i)
            2'd1:    ld_byte = line_data_i[15:8];
            2'd2:    ld_byte = line_data_i[23:16];
            2'd3:    ld_byte = line_data_i[31:24];
            default: ld_byte = line_data_i[7:0];
        endcase
        ld_half = ld_off_i[1] ? line_data_i[31:16] : line_data_i[15:0];
        case (rwidth_i)
            W_BYTE:  ld_data_o = {{24{rsign_i & ld_byte[7]}}, ld_byte};
            W_HALF:  ld_data_o = {{16{rsign_i & ld_half[15]}}, ld_half};
            default: ld_data_o = line_data_i;
        endcase
    end

    always_comb begin
        case (wwidth_i)
            W_BYTE: begin
                st_data_o = {4{wdata_i[7:0]}};
                st_strb_o = 4'b0001 << st_off_i;
            end
            W_HALF: begin
                st_data_o = {2{wdata_i[15:0]}};
                st_strb_o = st_off_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_data_o = wdata_i;
                st_strb_o = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// WB-stage data responder: direct-mapped, write-through, no-write-allocate cache
// in front of a req/ack memory port; stalls the pipeline via valid.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipeline_en,
    input  logic        ren,
    input  logic        wen,
    input  logic [31:0] addr,
    input  logic [2:0]  rwidth,
    input  logic        rsign,
    input  logic [2:0]  wwidth,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int IDX = $clog2(LINES);

    logic        act_q, is_rd_q, rsign_q, served_q;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  rwidth_q;
    logic [3:0]  wstrb_q;
    state_t      state_q, state_d;
    line_t       lines_q [LINES];
    line_t       cur_line, line_d;
    logic        line_we, hit, ack_done;
    logic [IDX-1:0]       idx;
    logic [TAG_MAX_W-1:0] slot_tag;
    logic [31:0] ld_data, st_data;
    logic [3:0]  st_strb;

    assign idx      = addr_q[IDX+1:2];
    assign slot_tag = TAG_MAX_W'(addr_q[31:IDX+2]);
    assign cur_line = lines_q[idx];
    assign hit      = act_q & cur_line.v & (cur_line.tag == slot_tag);
    assign ack_done = mem_ack & (state_q != S_IDLE);

    // Load steering works on the WB slot; store steering on the incoming EX request.
    dmem_lane_align u_align (
        .ld_off_i    (addr_q[1:0]),
        .rwidth_i    (rwidth_q),
        .rsign_i     (rsign_q),
        .line_data_i (cur_line.data),
        .ld_data_o   (ld_data),
        .st_off_i    (addr[1:0]),
        .wwidth_i    (wwidth),
        .wdata_i     (wdata),
        .st_data_o   (st_data),
        .st_strb_o   (st_strb)
    );

    always_comb begin
        state_d = state_q;
        line_we = 1'b0;
        line_d  = cur_line;
        case (state_q)
            S_IDLE: begin
                if (act_q && !served_q) begin
                    if (!is_rd_q)  state_d = S_WR;
                    else if (!hit) state_d = S_RD_MISS;
                end
            end
            S_RD_MISS: begin
                if (mem_ack) begin
                    state_d     = S_IDLE;
                    line_we     = 1'b1;
                    line_d.v    = 1'b1;
                    line_d.tag  = slot_tag;
                    line_d.data = mem_rdata;
                end
            end
            S_WR: begin
                if (mem_ack) begin
                    state_d = S_IDLE;
                    line_we = hit;  // no write-allocate: a store miss leaves the line alone
                    for (int b = 0; b < 4; b++)
                        line_d.data[b*8 +: 8] = wstrb_q[b] ? wdata_q[b*8 +: 8]
                                                           : cur_line.data[b*8 +: 8];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q    <= 1'b0;
            is_rd_q  <= 1'b0;
            addr_q   <= '0;
            rwidth_q <= W_WORD;
            rsign_q  <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            served_q <= 1'b0;
            state_q  <= S_IDLE;
        end else begin
            state_q <= state_d;
            if (pipeline_en) begin
                act_q    <= ren | wen;
                is_rd_q  <= ren;
                addr_q   <= addr;
                rwidth_q <= rwidth;
                rsign_q  <= rsign;
                wdata_q  <= st_data;
                wstrb_q  <= st_strb;
                served_q <= 1'b0;
            end else if (ack_done) begin
                served_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LINES; i++) lines_q[i] <= '0;
        end else if (line_we) begin
            lines_q[idx] <= line_d;
        end
    end

    assign valid     = !act_q | served_q | (is_rd_q & hit & (state_q == S_IDLE));
    assign rdata     = (is_rd_q & hit) ? ld_data : 32'd0;
    assign mem_req   = (state_q != S_IDLE);
    assign mem_we    = (state_q == S_WR);
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = wdata_q;
    assign mem_wstrb = (state_q == S_WR) ? wstrb_q : 4'b0000;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a word-memory reference model.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int LINES = 16;

    logic        clk = 1'b0, rst = 1'b1;
    logic        pipeline_en = 1'b0, ren = 1'b0, wen = 1'b0, rsign = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [2:0]  rwidth = W_WORD, wwidth = W_WORD;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic        valid, mem_req, mem_we;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    dmem_responder #(.LINES(LINES)) dut (
        .clk(clk), .rst(rst), .pipeline_en(pipeline_en), .ren(ren), .wen(wen),
        .addr(addr), .rwidth(rwidth), .rsign(rsign), .wwidth(wwidth), .wdata(wdata),
        .rdata(rdata), .valid(valid), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mreq_t;

    int          n_checks = 0, n_err = 0;
    logic [31:0] sb_q [$];
    mreq_t       mexp_q [$];
    logic [31:0] rmem [int unsigned];
    logic [31:0] smem [int unsigned];
    int unsigned ctag [int unsigned];
    int          lat_force = -1;
    bit          late_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    endtask

    function automatic logic [31:0] init_word(int unsigned wa);
        return (wa * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [31:0] rget(int unsigned wa);
        return rmem.exists(wa) ? rmem[wa] : init_word(wa);
    endfunction

    function automatic logic [31:0] sget(int unsigned wa);
        return smem.exists(wa) ? smem[wa] : init_word(wa);
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] w, logic [1:0] off, logic [2:0] rw, logic rs);
        logic [31:0] v;
        if (rw == W_BYTE) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (rs && v[7]) v = v | 32'hFFFFFF00;
        end else if (rw == W_HALF) begin
            v = (w >> (16 * off[1])) & 32'hFFFF;
            if (rs && v[15]) v = v | 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    // Reference: memory holds the truth (write-through); the cache map only predicts misses.
    task automatic model(input logic r, input logic w, input logic [31:0] a, input logic [2:0] rw,
                         input logic rs, input logic [2:0] ww, input logic [31:0] wd,
                         output logic [31:0] exp_rd, output bit stall);
        int unsigned wa, idx;
        mreq_t       m;
        logic [31:0] word;
        wa = a >> 2;
        idx = wa % LINES;
        exp_rd = 32'd0;
        stall = 1'b0;
        m.addr = wa << 2;
        m.wdata = 32'd0;
        m.wstrb = 4'd0;
        if (r) begin
            if (!(ctag.exists(idx) && ctag[idx] == wa)) begin
                m.we = 1'b0;
                mexp_q.push_back(m);
                ctag[idx] = wa;
                stall = 1'b1;
            end
            exp_rd = ref_load(rget(wa), a[1:0], rw, rs);
        end else if (w) begin
            stall = 1'b1;
            m.we = 1'b1;
            if (ww == W_BYTE) begin
                m.wdata = {4{wd[7:0]}};
                m.wstrb = 4'(1 << a[1:0]);
            end else if (ww == W_HALF) begin
                m.wdata = {2{wd[15:0]}};
                m.wstrb = a[1] ? 4'hC : 4'h3;
            end else begin
                m.wdata = wd;
                m.wstrb = 4'hF;
            end
            mexp_q.push_back(m);
            word = rget(wa);
            for (int b = 0; b < 4; b++)
                if (m.wstrb[b]) word[b*8 +: 8] = m.wdata[b*8 +: 8];
            rmem[wa] = word;
        end
    endtask

    // Called at posedge+1; waits for valid, advances the pipeline once.
    task automatic issue(input logic r, input logic w, input logic [31:0] a, input logic [2:0] rw,
                         input logic rs, input logic [2:0] ww, input logic [31:0] wd, input bit bubble);
        int          n;
        logic [31:0] exp_rd;
        bit          stall;
        n = 0;
        while (!valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!valid) begin
            n_checks++; n_err++;
            $display("FAIL valid_timeout: valid stayed %0b, required 1", valid);
            finish_sim();
        end
        if (bubble) begin
            repeat ($urandom_range(1, 2)) begin
                @(posedge clk); #1;
                chk("valid_held_idle", {31'd0, valid}, 32'd1);
            end
        end
        ren = r; wen = w; addr = a; rwidth = rw; rsign = rs; wwidth = ww; wdata = wd;
        pipeline_en = 1'b1;
        model(r, w, a, rw, rs, ww, wd, exp_rd, stall);
        @(posedge clk); #1;
        sb_q.push_back(exp_rd);
        pipeline_en = 1'b0; ren = 1'b0; wen = 1'b0;
        chk("valid_after_issue", {31'd0, valid}, {31'd0, !stall});
    endtask

    // Memory slave: checks each request against the model, holds it, then acks.
    initial begin : slave
        mreq_t cur, e;
        bit    busy;
        int    cnt;
        busy = 1'b0;
        cnt = 0;
        cur = '{1'b0, 32'd0, 32'd0, 4'd0};
        forever begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (rst) begin
                busy = 1'b0;
                continue;
            end
            if (late_ack) begin
                late_ack = 1'b0;
                mem_ack = 1'b1;
                mem_rdata = 32'hBAD0BAD0;
                continue;
            end
            if (busy) begin
                chk("mem_req_held", {31'd0, mem_req}, 32'd1);
                chk("mem_addr_stable", mem_addr, cur.addr);
                chk("mem_wstrb_stable", {28'd0, mem_wstrb}, {28'd0, cur.wstrb});
            end else if (mem_req) begin
                if (mexp_q.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL unexpected_mem_req: addr %08h we %0b, none required", mem_addr, mem_we);
                end else begin
                    e = mexp_q.pop_front();
                    chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, e.wstrb});
                    if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                end
                cur = '{mem_we, mem_addr, mem_wdata, mem_wstrb};
                busy = 1'b1;
                cnt = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 3));
            end
            if (busy) begin
                if (cnt == 0) begin
                    busy = 1'b0;
                    mem_ack = 1'b1;
                    if (!cur.we) begin
                        mem_rdata = sget(cur.addr >> 2);
                    end else begin
                        logic [31:0] w;
                        w = sget(cur.addr >> 2);
                        for (int b = 0; b < 4; b++)
                            if (cur.wstrb[b]) w[b*8 +: 8] = cur.wdata[b*8 +: 8];
                        smem[cur.addr >> 2] = w;
                    end
                end else begin
                    cnt--;
                end
            end
        end
    end

    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && valid && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("rdata", rdata, e);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        n_checks++; n_err++;
        $display("FAIL global_timeout: simulation still running");
        finish_sim();
    end

    initial begin : stim
        int k;
        int unsigned wa;
        logic [31:0] a;
        int sel;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Cold word load with fixed memory latency.
        rmem[32'h40] = 32'hDEADBEEF;
        smem[32'h40] = 32'hDEADBEEF;
        lat_force = 2;
        issue(1, 0, 32'h100, W_WORD, 0, W_WORD, 0, 0);
        k = 0;
        while (!valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("cold_miss_stall_cycles", k, 32'd4);
        lat_force = -1;

        // Byte hits, signed and unsigned.
        issue(1, 0, 32'h103, W_BYTE, 1, W_WORD, 0, 0);
        issue(1, 0, 32'h103, W_BYTE, 0, W_WORD, 0, 0);
        // Half store hit, then word reload merges.
        issue(0, 1, 32'h102, W_WORD, 0, W_HALF, 32'h00001234, 0);
        issue(1, 0, 32'h100, W_WORD, 0, W_WORD, 0, 0);
        issue(1, 0, 32'h102, W_HALF, 1, W_WORD, 0, 0);
        // Store miss without allocate, then load miss.
        issue(0, 1, 32'h200, W_WORD, 0, W_WORD, 32'hCAFEF00D, 0);
        issue(1, 0, 32'h200, W_WORD, 0, W_WORD, 0, 0);
        // Conflict eviction.
        issue(1, 0, 32'h100, W_WORD, 0, W_WORD, 0, 0);
        issue(1, 0, 32'h100 + 4 * LINES, W_WORD, 0, W_WORD, 0, 0);
        issue(1, 0, 32'h100, W_WORD, 0, W_WORD, 0, 1);

        // Reset while a read miss is outstanding.
        lat_force = 6;
        issue(1, 0, 32'h344, W_WORD, 0, W_WORD, 0, 0);
        k = 0;
        while (!mem_req && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rst_test_req_seen", {31'd0, mem_req}, 32'd1);
        #2;
        sb_q.delete();
        rst = 1'b1;
        #1;
        chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_valid", {31'd0, valid}, 32'd1);
        chk("midrst_rdata", rdata, 32'd0);
        ctag.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        lat_force = -1;
        #1;
        late_ack = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("late_ack_mem_req", {31'd0, mem_req}, 32'd0);
        chk("late_ack_valid", {31'd0, valid}, 32'd1);
        // Lines were invalidated: this must miss again.
        issue(1, 0, 32'h100, W_WORD, 0, W_WORD, 0, 0);

        for (int i = 0; i < 300; i++) begin
            wa = $urandom_range(0, 3) * LINES + $urandom_range(0, 5) + 32'h40;
            a = (wa << 2) | $urandom_range(0, 3);
            sel = $urandom_range(0, 9);
            issue(sel <= 5, sel >= 6 && sel <= 8, a, 3'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 2)), $urandom, $urandom_range(0, 3) == 0);
        end

        issue(0, 0, 32'h0, W_WORD, 0, W_WORD, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        chk("mem_expect_drained", mexp_q.size(), 32'd0);
        finish_sim();
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-side responder for the core's EX/WB load/store interface. It accepts one load or store per pipeline advance and answers it in the following (WB) cycle. It holds `valid` low to stall the whole pipeline until the answer is ready. Internally it is a direct-mapped, one-word-per-line, write-through, no-write-allocate cache backed by a simple req/ack memory port.

Parameters:
LINES, 64, number of cache lines (power of 2, ≥2); index = addr[IDX+1:2], IDX = log2(LINES)
TAG_W, 30-IDX, derived tag width = addr[31:IDX+2]

Ports:
clk  input  1  core clock
rst  input  1  reset, asynchronous, active-high
pipeline_en  input  1  pipeline advance strobe; samples EX request
ren  input  1  EX: load request
wen  input  1  EX: store request (ren&wen never both 1)
addr  input  32  EX: byte address
rwidth  input  3  EX: load width (package encoding)
rsign  input  1  EX: load sign-extend
wwidth  input  3  EX: store width
wdata  input  32  EX: store data, right-aligned
rdata  output  32  WB: load result, extended to 32 bits
valid  output  1  WB: result ready / no stall needed
mem_req  output  1  memory request, held until ack
mem_we  output  1  1 = write, 0 = read
mem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
mem_wdata  output  32  lane-aligned store data
mem_wstrb  output  4  byte strobes (all zero for reads)
mem_ack  input  1  one-cycle completion pulse
mem_rdata  input  32  read word, valid with mem_ack

Behaviour:
- WB slot register: on posedge with pipeline_en=1, load {act=ren|wen, is_rd=ren, addr, widths, rsign, lane-aligned wdata, strobes}; served<=0. Holds while pipeline_en=0.
- Reset (async): all line valid bits 0, slot act=0, served=0, FSM=IDLE, mem_req=0, mem_we=0, mem_wstrb=0, rdata=0, valid=1. Reset mid-transaction drops mem_req immediately; the memory side discards any outstanding request.
- hit = act & line[idx].v & (line[idx].tag == slot tag).
- valid = !act | served | (is_rd & hit & state==IDLE). Combinational, zero latency on read hit.
- FSM states:
  - IDLE: if act & !served & is_rd & !hit → RD_MISS; if act & !served & !is_rd → WR.
  - RD_MISS: mem_req=1, mem_we=0, wstrb=0. On mem_ack, write line {v=1, tag, mem_rdata}, served<=1 → IDLE.
  - WR: mem_req=1, mem_we=1, wdata/wstrb from slot. On mem_ack, if hit merge strobed bytes into line (miss: line untouched), served<=1 → IDLE.
- mem_* signals are stable from assertion until the ack cycle. mem_req=0 in the cycle after ack. Acks outside RD_MISS/WR are ignored.
- Minimum stall: read miss = 1 + memory latency cycles; store ≥ 2 cycles. Store hit still stalls until ack (write-through).
- rdata (combinational from line data when is_rd & hit, else 0):
  - Byte: lane addr[1:0].
  - Half: lane addr[1] (addr[0] ignored).
  - Word: addr[1:0] ignored.
  - Extension: sign if rsign, else zero.
- Store lane alignment: byte → wdata[7:0] replicated, wstrb=1<<addr[1:0]; half → wdata[15:0] replicated, wstrb = addr[1]?1100:0011; word → wstrb=1111.
- Misalignment is not trapped.
- A new slot is never loaded while valid=0, since pipeline_en implies valid.
- If valid=1 but pipeline_en is held low by the icache, the request is not reissued because served is set.

Decomposition:
- Package dmem_pkg: width encodings W_BYTE=3'd0, W_HALF=3'd1, W_WORD=3'd2; FSM enum {S_IDLE, S_RD_MISS, S_WR}; line struct {v, tag, data}.
- One sub-module: dmem_lane_align (combinational), containing load extract/extend plus store replicate/strobe.
- Tag/data array and FSM live in dmem_responder.

Test Plan:
1. Cold load word, addr 0x100, memory returns 0xDEADBEEF after 3 cycles → mem_req with mem_addr 0x100; valid low 4 cycles; then rdata 0xDEADBEEF, valid=1.
2. Repeat load byte, addr 0x103, rsign=1 → no mem_req, valid=1 same cycle, rdata 0xFFFFFFDE; with rsign=0 → 0x000000DE.
3. Store half 0x1234 to 0x102 (line cached) → mem_we=1, wstrb 1100, mem_wdata 0x12341234; after ack a load word at 0x100 hits and returns 0x1234BEEF.
4. Store to uncached 0x200, then load 0x200 → store completes via ack, no allocate; the load misses and issues a memory read.
5. Conflict: load 0x100, then load 0x100+4*LINES → second load misses and evicts; a third load at 0x100 misses again.
6. Assert rst during RD_MISS before ack → mem_req=0 immediately, valid=1, all lines invalid; a late mem_ack is ignored.
